poly_key_tone_gen: RTL and testbench
====================================

// Module: poly_key_tone_gen
// PURPOSE
//  Parametrised key-to-tone generator for the FPGA piano. Takes NUM_KEYS key enables
//  and drives one speaker pin with a true 50%-duty square wave at the selected note.
//  Highest-indexed pressed key wins. Note changes and releases are glitch-free:
//  they take effect only at a half-period boundary. Sits between key debouncers and speaker pin.
// PARAMETERS
//  NUM_KEYS      8   number of key inputs, 1..8; key i plays piano_pkg::HALF_PERIOD[i]
//  CNT_W         16  half-period counter width; must hold HALF_PERIOD[0]-1
//  PERIOD_SHIFT  0   table values >> PERIOD_SHIFT before use (sim speed-up; 0 in silicon)
// PORTS
//  clk        in   1          system clock, 25 MHz
//  rst_n      in   1          synchronous active-low reset
//  key_en     in   NUM_KEYS   key pressed = 1, already debounced, clk-synchronous
//  speaker    out  1          square-wave audio output
//  active     out  1          1 while in PLAY state
//  note_idx   out  3          index of the note currently sounding; 0 when idle
//  counter    out  CNT_W      half-period counter (debug)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): speaker=0, active=0, note_idx=0, counter=0, state=IDLE.
//  Selection: sel = highest i with key_en[i]=1; any = |key_en. Combinational from key_en.
//  hp = HALF_PERIOD[sel] >> PERIOD_SHIFT, >> oct when OCTAVE_SHIFT_EN. hp < 2 is a config error.
//  FSM IDLE: counter=0, speaker=0. If any: go PLAY next edge, latch note_idx=sel, cur_hp=hp,
//   speaker<=1, counter<=0. Latency: key edge to speaker rising = 1 clk.
//  FSM PLAY: counter increments each clk. At counter==cur_hp-1 (boundary):
//   counter<=0. If any: speaker toggles, note_idx<=sel, cur_hp<=hp (new note from next half).
//   If !any: speaker<=0, active<=0, go IDLE.
//  Release mid half-cycle: current half completes; worst-case stop latency cur_hp clks.
//  Key change mid half-cycle: no effect until boundary. No truncated or stretched half-periods.
//  Key change on the boundary cycle: the new sel is used.
//  Release, then press again before the boundary: treated as held; no silence.
//  rst_n low mid-operation: immediate return to reset values on that edge; no drain.
//  Counter never exceeds cur_hp-1. No wrap past 2^CNT_W.
//  active is registered. active=1 exactly when state=PLAY.
// CONFIGURATION
//  OCTAVE_SHIFT_EN defined: adds input port 'octave' in 2, sampled with sel at the same points.
//   hp further >> octave (0..3 octaves up).
//   Octave change, like note change, applies only at boundaries.
//  OCTAVE_SHIFT_EN undefined: no octave port; hp = table >> PERIOD_SHIFT only.
// STRUCTURE
//  Package piano_pkg: NOTE_W=3. Note enum C4,D4,E4,F4,G4,A4,B4,C5.
//   HALF_PERIOD[8] at 25 MHz = 47776,42566,37921,35793,31888,28409,25310,23889.
//  Sub-module tone_half_div: counter + compare + toggle.
//   Inputs: hp, load, run. Output: boundary strobe. Top holds FSM and selection.
// TESTING  (PERIOD_SHIFT=8: C4 hp=186, D4 hp=166, A4 hp=110, C5 hp=93)
//  1 Reset with key_en=8'h01 held -> speaker=0, active=0 during rst_n=0.
//   Then speaker rises 1 clk after release; period = 372 clk, high 186 / low 186.
//  2 key_en=8'h21 (C4+A4) -> note_idx=5, full period 220 clk, 50% duty.
//  3 Play C4, switch to 8'h80 at counter=50 -> C4 half completes to 186 clks.
//   Next half 93 clks; note_idx=7 from that boundary.
//  4 Play A4, key_en=0 at counter=10 -> speaker holds until counter=109.
//   Then speaker=0, active=0 next edge; counter=0.
//  5 rst_n=0 for 1 clk mid-half while playing D4 -> all outputs 0 next edge.
//   Then replay starts 1 clk after rst_n=1.
//  6 OCTAVE_SHIFT_EN, C4, octave=1 -> hp=93, period 186.
//   octave=2 mid-half -> 46-clk halves from next boundary.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared note table and FSM state type for the key-to-tone generator.
package piano_pkg;

    localparam int unsigned NOTE_W = 3;

    typedef enum logic [NOTE_W-1:0] {C4, D4, E4, F4, G4, A4, B4, C5} note_e;

    typedef enum logic {StIdle, StPlay} tone_state_e;

    // Half-period in 25 MHz clocks. Entry 0 (C4) is the rightmost element.
    localparam logic [7:0][15:0] HALF_PERIOD = {
        16'd23889, 16'd25310, 16'd28409, 16'd31888,
        16'd35793, 16'd37921, 16'd42566, 16'd47776
    };

endpackage

// File: rtl/tone_half_div.sv
// Half-period divider: latches hp on load and strobes boundary on the last clock of each half.
module tone_half_div #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] hp,
    input  logic             load,
    input  logic             run,
    output logic             boundary,
    output logic [CNT_W-1:0] counter
);

    logic [CNT_W-1:0] cur_hp_q;
    logic [CNT_W-1:0] cnt_q;

    assign boundary = run && (cnt_q == cur_hp_q - CNT_W'(1));
    assign counter  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_hp_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (load) begin
                cur_hp_q <= hp;
            end
            if (load || !run || boundary) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/poly_key_tone_gen.sv
// Highest-pressed-key square-wave tone generator; note changes land only on half-period edges.
// Optional OCTAVE_SHIFT_EN adds a 2-bit octave input that shortens the half-period.
module poly_key_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef OCTAVE_SHIFT_EN
    input  logic [1:0]          octave,
`endif
    input  logic [NUM_KEYS-1:0] key_en,
    output logic                speaker,
    output logic                active,
    output logic [NOTE_W-1:0]   note_idx,
    output logic [CNT_W-1:0]    counter
);

    tone_state_e       state_q, state_d;
    logic              speaker_q, speaker_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [NOTE_W-1:0] sel;
    logic              any;
    logic [CNT_W-1:0]  hp;
    logic              load;
    logic              boundary;

    // Later iterations overwrite earlier ones, so the highest pressed key wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_en[i]) begin
                sel = NOTE_W'(i);
            end
        end
    end

    assign any = |key_en;

`ifdef OCTAVE_SHIFT_EN
    assign hp = CNT_W'((32'(HALF_PERIOD[sel]) >> PERIOD_SHIFT) >> octave);
`else
    assign hp = CNT_W'(32'(HALF_PERIOD[sel]) >> PERIOD_SHIFT);
`endif

    tone_half_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .hp      (hp),
        .load    (load),
        .run     (state_q == StPlay),
        .boundary(boundary),
        .counter (counter)
    );

    always_comb begin
        state_d   = state_q;
        speaker_d = speaker_q;
        note_d    = note_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                speaker_d = 1'b0;
                note_d    = '0;
                if (any) begin
                    state_d   = StPlay;
                    speaker_d = 1'b1;
                    note_d    = sel;
                    load      = 1'b1;
                end
            end
            StPlay: begin
                if (boundary) begin
                    if (any) begin
                        speaker_d = ~speaker_q;
                        note_d    = sel;
                        load      = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        speaker_d = 1'b0;
                        note_d    = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            speaker_q <= 1'b0;
            note_q    <= '0;
        end else begin
            state_q   <= state_d;
            speaker_q <= speaker_d;
            note_q    <= note_d;
        end
    end

    assign speaker  = speaker_q;
    assign active   = (state_q == StPlay);
    assign note_idx = note_q;

endmodule

// File: tb/tb_poly_key_tone_gen.sv
// Self-checking bench for poly_key_tone_gen (PERIOD_SHIFT=8); octave steps only with OCTAVE_SHIFT_EN.
module tb_poly_key_tone_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  key_en = 8'h00;
    logic        speaker;
    logic        active;
    logic [2:0]  note_idx;
    logic [15:0] counter;
`ifdef OCTAVE_SHIFT_EN
    logic [1:0]  octave = 2'd0;
`endif

    always #5 clk = ~clk;

    poly_key_tone_gen #(
        .NUM_KEYS    (8),
        .CNT_W       (16),
        .PERIOD_SHIFT(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef OCTAVE_SHIFT_EN
        .octave  (octave),
`endif
        .key_en  (key_en),
        .speaker (speaker),
        .active  (active),
        .note_idx(note_idx),
        .counter (counter)
    );

    int total = 0;
    int bad   = 0;
    int tbl[8] = '{47776, 42566, 37921, 35793, 31888, 28409, 25310, 23889};

    // Reference: whether a note sounds, its level, and clocks elapsed in the current half.
    bit m_play = 0;
    bit m_spk  = 0;
    int m_note = 0;
    int m_half = 0;
    int m_el   = 0;

    function automatic int cur_oct();
`ifdef OCTAVE_SHIFT_EN
        return int'(octave);
`else
        return 0;
`endif
    endfunction

    function automatic int top_key(input logic [7:0] k);
        int r = -1;
        for (int i = 0; i < 8; i++) if (k[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        int s = top_key(key_en);
        if (!rst_n) begin
            m_play = 0; m_spk = 0; m_note = 0; m_half = 0; m_el = 0;
        end else if (!m_play) begin
            if (s >= 0) begin
                m_play = 1; m_spk = 1; m_note = s; m_el = 0;
                m_half = (tbl[s] >> 8) >> cur_oct();
            end
        end else begin
            m_el++;
            if (m_el == m_half) begin
                m_el = 0;
                if (s >= 0) begin
                    m_spk  = !m_spk;
                    m_note = s;
                    m_half = (tbl[s] >> 8) >> cur_oct();
                end else begin
                    m_play = 0; m_spk = 0; m_note = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("speaker", 32'(speaker), 32'(m_spk));
        chk("active", 32'(active), 32'(m_play));
        chk("note_idx", 32'(note_idx), 32'(m_note));
        chk("counter", 32'(counter), 32'(m_el));
    endtask

    // Counts consecutive samples (from the current one) where speaker stays at lvl.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (speaker === lvl && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_cnt(input int c);
        int n = 0;
        while (counter !== 16'(c) && n < 2000) begin
            tick();
            n++;
        end
        chk("cnt_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int n;
        int m;
        bit held;

        // 1: reset with C4 held, then 372-clk period
        rst_n  = 1'b0;
        key_en = 8'h01;
        tick(); tick(); tick();
        chk("t1_rst_speaker", 32'(speaker), 32'd0);
        chk("t1_rst_active", 32'(active), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t1_rise", 32'(speaker), 32'd1);
        run_len(1'b1, n);
        chk("t1_high", n, 186);
        run_len(1'b0, n);
        chk("t1_low", n, 186);

        // 2: C4+A4 -> A4 wins from next boundary, 110/110
        key_en = 8'h21;
        n = 0;
        while (note_idx !== 3'd5 && n < 400) begin
            tick();
            n++;
        end
        chk("t2_timeout", 32'(n < 400), 32'd1);
        run_len(1'b0, n);
        chk("t2_low", n, 110);
        chk("t2_note", 32'(note_idx), 32'd5);
        run_len(1'b1, n);
        chk("t2_high", n, 110);

        // 3: C4, switch to C5 at counter 50; C4 half stays 186
        key_en = 8'h00;
        wait_idle();
        key_en = 8'h01;
        tick();
        n = 0;
        while (counter !== 16'd50 && n < 400) begin
            tick();
            n++;
        end
        key_en = 8'h80;
        run_len(1'b1, m);
        chk("t3_c4_half", n + m, 186);
        chk("t3_note", 32'(note_idx), 32'd7);
        run_len(1'b0, n);
        chk("t3_c5_half", n, 93);

        // 4: A4 released at counter 10 -> half completes, then idle
        key_en = 8'h00;
        wait_idle();
        key_en = 8'h20;
        tick();
        wait_cnt(10);
        key_en = 8'h00;
        n    = 0;
        held = 1;
        while (active === 1'b1 && n < 400) begin
            if (speaker !== 1'b1) held = 0;
            tick();
            n++;
        end
        chk("t4_stop_latency", n, 100);
        chk("t4_held", 32'(held), 32'd1);
        chk("t4_speaker", 32'(speaker), 32'd0);
        chk("t4_counter", 32'(counter), 32'd0);

        // 5: reset pulse mid-half on D4, replay 1 clk after release
        key_en = 8'h02;
        tick();
        wait_cnt(30);
        rst_n = 1'b0;
        tick();
        chk("t5_speaker", 32'(speaker), 32'd0);
        chk("t5_active", 32'(active), 32'd0);
        chk("t5_note", 32'(note_idx), 32'd0);
        chk("t5_counter", 32'(counter), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_replay", 32'(speaker), 32'd1);
        chk("t5_replay_note", 32'(note_idx), 32'd1);

`ifdef OCTAVE_SHIFT_EN
        // 6: octave shift, applied only at boundaries
        key_en = 8'h00;
        wait_idle();
        octave = 2'd1;
        key_en = 8'h01;
        tick();
        run_len(1'b1, n);
        chk("t6_oct1_high", n, 93);
        tick(); tick(); tick();
        octave = 2'd2;
        run_len(1'b0, n);
        chk("t6_oct1_low", n, 93);
        run_len(1'b1, n);
        chk("t6_oct2_high", n, 46);
        run_len(1'b0, n);
        chk("t6_oct2_low", n, 46);
        octave = 2'd0;
`endif

        // Random keys, rare resets, short release/re-press glitches
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       key_en = 8'h00;
                    1:       key_en = 8'(1 << $urandom_range(0, 7));
                    default: key_en = 8'($urandom);
                endcase
            end
            rst_n = ($urandom_range(0, 599) != 0);
`ifdef OCTAVE_SHIFT_EN
            if ($urandom_range(0, 99) == 0) octave = 2'($urandom_range(0, 3));
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
